// File: rtl/axi_router_pkg.sv
// Shared types and default address map for the AXI address-channel router.
// Used by axi_addr_router and axi_addr_match.
package axi_router_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        ERRW,
        ERR
    } state_e;

    localparam int DEF_NUM_SLAVES = 5;
    localparam int DEF_ADDR_W     = 32;

    // Slave 0 sits in the LSBs of each packed table.
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_BASE = {
        32'hF002_0000, 32'hF001_0000, 32'hF000_0000, 32'h2000_0000, 32'h0000_0000
    };
    localparam logic [DEF_NUM_SLAVES*DEF_ADDR_W-1:0] DEF_SLV_MASK = {
        32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hF000_0000, 32'hFFFF_0000
    };

endpackage

// File: rtl/axi_addr_match.sv
// Combinational priority base/mask address matcher: lowest matching slave index wins.
// Reports a miss (with sel=0) when no slave window contains the address.
import axi_router_pkg::*;

module axi_addr_match #(
    parameter int                              NUM_SLAVES = DEF_NUM_SLAVES,
    parameter int                              ADDR_W     = DEF_ADDR_W,
    parameter int                              SEL_W      = 3,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]    SLV_BASE   = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]    SLV_MASK   = DEF_SLV_MASK
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel,
    output logic              miss
);

    // Scanning from the top down lets the lowest matching index overwrite the rest.
    always_comb begin
        sel  = '0;
        miss = 1'b1;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((addr & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                sel  = SEL_W'(i);
                miss = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_addr_router.sv
// AXI address-channel router with in-order outstanding tracking to a single target.
// Define AXI_ADDR_ROUTER_DECERR_EN to answer unmapped addresses with DECERR instead of routing to slave 0.
import axi_router_pkg::*;

module axi_addr_router #(
    parameter int                              NUM_SLAVES = 5,
    parameter int                              ADDR_W     = 32,
    parameter int                              RSP_W      = 32,
    parameter int                              MAX_OUTST  = 4,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]    SLV_BASE   = DEF_SLV_BASE,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]    SLV_MASK   = DEF_SLV_MASK
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        s_addr_valid,
    output logic                        s_addr_ready,
    input  logic [ADDR_W-1:0]           s_addr,
    output logic                        s_rsp_valid,
    input  logic                        s_rsp_ready,
    output logic [RSP_W-1:0]            s_rsp_data,
    output logic [1:0]                  s_rsp_resp,
    output logic [NUM_SLAVES-1:0]       m_addr_valid,
    input  logic [NUM_SLAVES-1:0]       m_addr_ready,
    output logic [ADDR_W-1:0]           m_addr,
    input  logic [NUM_SLAVES-1:0]       m_rsp_valid,
    output logic [NUM_SLAVES-1:0]       m_rsp_ready,
    input  logic [NUM_SLAVES*RSP_W-1:0] m_rsp_data,
    input  logic [NUM_SLAVES*2-1:0]     m_rsp_resp
);

    localparam int SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   cur_sel_q, cur_sel_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;

    logic [SEL_W-1:0]   match_sel;
    logic               match_miss;
    logic               issue_ok, issue_hs, rsp_active, rsp_hs, sel_ready;

    axi_addr_match #(
        .NUM_SLAVES (NUM_SLAVES),
        .ADDR_W     (ADDR_W),
        .SEL_W      (SEL_W),
        .SLV_BASE   (SLV_BASE),
        .SLV_MASK   (SLV_MASK)
    ) u_match (
        .addr (s_addr),
        .sel  (match_sel),
        .miss (match_miss)
    );

`ifndef AXI_ADDR_ROUTER_DECERR_EN
    logic unused_miss;
    assign unused_miss = match_miss;
`endif

    assign m_addr = addr_q;

    // A new target may only be issued once everything outstanding has drained,
    // which keeps responses in request order without per-transaction IDs.
    always_comb begin
        issue_ok     = ((cnt_q == '0) || (sel_q == cur_sel_q)) && (cnt_q < CNT_W'(MAX_OUTST));
        rsp_active   = (cnt_q != '0) && (state_q != ERR);
        s_addr_ready = (state_q == IDLE) && !rst;
        m_addr_valid = '0;
        m_rsp_ready  = '0;
        s_rsp_valid  = 1'b0;
        s_rsp_data   = '0;
        s_rsp_resp   = RESP_OKAY;
        sel_ready    = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                m_addr_valid[i] = (state_q == ISSUE) && issue_ok;
                sel_ready       = m_addr_ready[i];
            end
            if (rsp_active && (cur_sel_q == SEL_W'(i))) begin
                s_rsp_valid    = m_rsp_valid[i];
                s_rsp_data     = m_rsp_data[i*RSP_W +: RSP_W];
                s_rsp_resp     = m_rsp_resp[i*2 +: 2];
                m_rsp_ready[i] = s_rsp_ready;
            end
        end
`ifdef AXI_ADDR_ROUTER_DECERR_EN
        if (state_q == ERR) begin
            s_rsp_valid = 1'b1;
            s_rsp_resp  = RESP_DECERR;
        end
`endif
        issue_hs = (state_q == ISSUE) && issue_ok && sel_ready;
        rsp_hs   = rsp_active && s_rsp_valid && s_rsp_ready;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_sel_d = cur_sel_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        case (state_q)
            IDLE: begin
                if (s_addr_valid && s_addr_ready) begin
                    addr_d  = s_addr;
                    sel_d   = match_sel;
                    state_d = ISSUE;
`ifdef AXI_ADDR_ROUTER_DECERR_EN
                    if (match_miss) begin
                        state_d = ERRW;
                    end
`endif
                end
            end
            ISSUE: begin
                if (issue_hs) begin
                    cur_sel_d = sel_q;
                    state_d   = IDLE;
                end
            end
`ifdef AXI_ADDR_ROUTER_DECERR_EN
            ERRW: begin
                if (cnt_q == '0) begin
                    state_d = ERR;
                end
            end
            ERR: begin
                if (s_rsp_ready) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
        // Issue and response in the same cycle cancel out.
        case ({issue_hs, rsp_hs})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cur_sel_q <= '0;
            sel_q     <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cur_sel_q <= cur_sel_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
        end
    end

endmodule

// File: tb/tb_axi_addr_router.sv
// Self-checking bench for axi_addr_router: decode table plus hand sequences for
// outstanding limits, ordering stalls, simultaneous handshakes, unmapped addresses and reset.
import axi_router_pkg::*;

module tb_axi_addr_router;

    localparam int NS = 5;
    localparam int AW = 32;
    localparam int RW = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_addr_valid;
    logic            s_addr_ready;
    logic [AW-1:0]   s_addr;
    logic            s_rsp_valid;
    logic            s_rsp_ready;
    logic [RW-1:0]   s_rsp_data;
    logic [1:0]      s_rsp_resp;
    logic [NS-1:0]   m_addr_valid;
    logic [NS-1:0]   m_addr_ready;
    logic [AW-1:0]   m_addr;
    logic [NS-1:0]   m_rsp_valid;
    logic [NS-1:0]   m_rsp_ready;
    logic [NS*RW-1:0] m_rsp_data;
    logic [NS*2-1:0] m_rsp_resp;

    always #5 clk = ~clk;

    axi_addr_router dut (
        .clk          (clk),
        .rst          (rst),
        .s_addr_valid (s_addr_valid),
        .s_addr_ready (s_addr_ready),
        .s_addr       (s_addr),
        .s_rsp_valid  (s_rsp_valid),
        .s_rsp_ready  (s_rsp_ready),
        .s_rsp_data   (s_rsp_data),
        .s_rsp_resp   (s_rsp_resp),
        .m_addr_valid (m_addr_valid),
        .m_addr_ready (m_addr_ready),
        .m_addr       (m_addr),
        .m_rsp_valid  (m_rsp_valid),
        .m_rsp_ready  (m_rsp_ready),
        .m_rsp_data   (m_rsp_data),
        .m_rsp_resp   (m_rsp_resp)
    );

    typedef struct {
        logic [31:0] addr;
        int          sel;
        logic [31:0] data;
        logic [1:0]  resp;
    } vec_t;

    typedef struct {
        logic [NS-1:0] valid;
        logic [31:0]   addr;
    } req_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_exp_t;

    req_exp_t req_q[$];
    rsp_exp_t rsp_q[$];
    vec_t     vecs[7];
    int       n_compared   = 0;
    int       n_mismatched = 0;
    int       model_cnt    = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkCnt(input string name);
        checkOutput(name, 64'(dut.cnt_q), 64'(model_cnt));
    endtask

    task automatic emptyQueueFail(input string name);
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL %s: DUT produced output with no expectation queued", name);
    endtask

    // Called at a falling edge; presents a request for one cycle.
    task automatic sendReq(input logic [31:0] addr, input logic [NS-1:0] exp_valid, input bit expect_issue);
        s_addr       = addr;
        s_addr_valid = 1'b1;
        if (expect_issue) req_q.push_back('{exp_valid, addr});
        #1;
        checkOutput("s_addr_ready_idle", 64'(s_addr_ready), 64'd1);
        checkOutput("pre_issue_valid", 64'(m_addr_valid), 64'd0);
        @(negedge clk);
        s_addr_valid = 1'b0;
    endtask

    task automatic popReq();
        req_exp_t e;
        if (req_q.size() == 0) begin
            emptyQueueFail("req_queue");
        end else begin
            e = req_q.pop_front();
            checkOutput("m_addr_valid", 64'(m_addr_valid), 64'(e.valid));
            checkOutput("m_addr", 64'(m_addr), 64'(e.addr));
        end
    endtask

    task automatic popRsp();
        rsp_exp_t e;
        if (rsp_q.size() == 0) begin
            emptyQueueFail("rsp_queue");
        end else begin
            e = rsp_q.pop_front();
            checkOutput("s_rsp_data", 64'(s_rsp_data), 64'(e.data));
            checkOutput("s_rsp_resp", 64'(s_rsp_resp), 64'(e.resp));
        end
    endtask

    task automatic issueReq();
        m_addr_ready = '1;
        #1;
        popReq();
        @(negedge clk);
        m_addr_ready = '0;
        model_cnt++;
    endtask

    task automatic clearRsp();
        m_rsp_valid = '0;
        m_rsp_data  = '0;
        m_rsp_resp  = '0;
        s_rsp_ready = 1'b0;
    endtask

    task automatic respond(input int slave, input logic [31:0] data, input logic [1:0] resp);
        m_rsp_valid                 = NS'(1) << slave;
        m_rsp_data[slave*RW +: RW]  = data;
        m_rsp_resp[slave*2 +: 2]    = resp;
        s_rsp_ready                 = 1'b1;
        rsp_q.push_back('{data, resp});
        #1;
        checkOutput("s_rsp_valid", 64'(s_rsp_valid), 64'd1);
        checkOutput("m_rsp_ready", 64'(m_rsp_ready), 64'(NS'(1) << slave));
        if (s_rsp_valid) popRsp();
        @(negedge clk);
        clearRsp();
        model_cnt--;
    endtask

    task automatic checkStall(input int cycles);
        m_addr_ready = '1;
        repeat (cycles) begin
            #1;
            checkOutput("stall_valid", 64'(m_addr_valid), 64'd0);
            checkOutput("stall_addr_ready", 64'(s_addr_ready), 64'd0);
            @(negedge clk);
        end
        m_addr_ready = '0;
    endtask

    task automatic applyStimulus(input vec_t v);
        sendReq(v.addr, NS'(1) << v.sel, 1'b1);
        issueReq();
        checkCnt("cnt_after_issue");
        respond(v.sel, v.data, v.resp);
        checkCnt("cnt_after_rsp");
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{32'h0000_1234, 0, 32'h1111_0000, RESP_OKAY};
        vecs[1] = '{32'h0000_FFFF, 0, 32'h2222_0001, 2'b10};
        vecs[2] = '{32'h2ABC_0000, 1, 32'h3333_0002, RESP_OKAY};
        vecs[3] = '{32'h2FFF_FFFF, 1, 32'h4444_0003, 2'b01};
        vecs[4] = '{32'hF000_0010, 2, 32'h5555_0004, RESP_OKAY};
        vecs[5] = '{32'hF001_0040, 3, 32'h0000_00A5, RESP_OKAY};
        vecs[6] = '{32'hF002_FFFC, 4, 32'h6666_0006, 2'b10};

        rst          = 1'b1;
        s_addr_valid = 1'b0;
        s_addr       = '0;
        m_addr_ready = '0;
        clearRsp();
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_s_addr_ready", 64'(s_addr_ready), 64'd0);
        checkOutput("rst_m_addr_valid", 64'(m_addr_valid), 64'd0);
        checkOutput("rst_m_rsp_ready", 64'(m_rsp_ready), 64'd0);
        checkOutput("rst_s_rsp_valid", 64'(s_rsp_valid), 64'd0);
        checkOutput("rst_m_addr", 64'(m_addr), 64'd0);
        checkOutput("rst_state", 64'(dut.state_q), 64'(IDLE));
        checkCnt("rst_cnt");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);

        // Fill to the outstanding limit, then a fifth request must wait for a response.
        for (int i = 0; i < 4; i++) begin
            sendReq(32'h2000_1000, 5'b00010, 1'b1);
            issueReq();
        end
        checkCnt("cnt_full");
        sendReq(32'h2000_1000, 5'b00010, 1'b1);
        checkStall(3);
        respond(1, 32'hB000_0000, RESP_OKAY);
        checkCnt("cnt_after_one_rsp");
        issueReq();
        checkCnt("cnt_refilled");
        for (int i = 0; i < 4; i++) respond(1, 32'hB000_0001 + i, RESP_OKAY);
        checkCnt("cnt_drained");

        // Switching target must wait until the previous target has drained.
        sendReq(32'h2000_0004, 5'b00010, 1'b1);
        issueReq();
        sendReq(32'h2100_0000, 5'b00010, 1'b1);
        issueReq();
        sendReq(32'hF002_0100, 5'b10000, 1'b1);
        checkStall(2);
        respond(1, 32'hC000_0001, RESP_OKAY);
        checkStall(1);
        respond(1, 32'hC000_0002, RESP_OKAY);
        checkCnt("cnt_switch_drained");
        issueReq();
        respond(4, 32'hC000_0004, RESP_OKAY);
        checkCnt("cnt_switch_done");

        // Issue and response handshakes in the same cycle.
        sendReq(32'hF001_0000, 5'b01000, 1'b1);
        issueReq();
        sendReq(32'hF001_0008, 5'b01000, 1'b1);
        m_addr_ready        = '1;
        m_rsp_valid         = 5'b01000;
        m_rsp_data[3*RW +: RW] = 32'h0000_00DD;
        m_rsp_resp[3*2 +: 2]   = RESP_OKAY;
        s_rsp_ready         = 1'b1;
        rsp_q.push_back('{32'h0000_00DD, RESP_OKAY});
        #1;
        popReq();
        checkOutput("simul_rsp_valid", 64'(s_rsp_valid), 64'd1);
        popRsp();
        @(negedge clk);
        m_addr_ready = '0;
        clearRsp();
        checkOutput("simul_cnt", 64'(dut.cnt_q), 64'd1);
        respond(3, 32'h0000_00EE, RESP_OKAY);
        checkCnt("cnt_simul_done");

        // A response offered while nothing is outstanding is ignored.
        m_rsp_valid = 5'b00001;
        m_rsp_data[RW-1:0] = 32'hDEAD_BEEF;
        s_rsp_ready = 1'b1;
        #1;
        checkOutput("idle_rsp_valid", 64'(s_rsp_valid), 64'd0);
        checkOutput("idle_rsp_ready", 64'(m_rsp_ready), 64'd0);
        @(negedge clk);
        clearRsp();
        checkCnt("cnt_idle_rsp");

        // Unmapped address with one transaction still outstanding to slave 0.
        sendReq(32'h0000_0100, 5'b00001, 1'b1);
        issueReq();
`ifdef AXI_ADDR_ROUTER_DECERR_EN
        sendReq(32'h5000_0000, 5'b00000, 1'b0);
        #1;
        checkOutput("errw_valid", 64'(m_addr_valid), 64'd0);
        checkOutput("errw_rsp_valid", 64'(s_rsp_valid), 64'd0);
        checkOutput("errw_addr_ready", 64'(s_addr_ready), 64'd0);
        @(negedge clk);
        respond(0, 32'h0000_0F0F, RESP_OKAY);
        #1;
        checkOutput("errw_drained_rsp_valid", 64'(s_rsp_valid), 64'd0);
        @(negedge clk);
        m_rsp_valid = 5'b00001;
        m_rsp_data[RW-1:0] = 32'h1234_5678;
        repeat (3) begin
            #1;
            checkOutput("decerr_valid", 64'(s_rsp_valid), 64'd1);
            checkOutput("decerr_resp", 64'(s_rsp_resp), 64'(RESP_DECERR));
            checkOutput("decerr_data", 64'(s_rsp_data), 64'd0);
            checkOutput("decerr_m_rsp_ready", 64'(m_rsp_ready), 64'd0);
            @(negedge clk);
        end
        clearRsp();
        s_rsp_ready = 1'b1;
        #1;
        checkOutput("decerr_final_valid", 64'(s_rsp_valid), 64'd1);
        @(negedge clk);
        s_rsp_ready = 1'b0;
        #1;
        checkOutput("decerr_back_idle", 64'(s_addr_ready), 64'd1);
        @(negedge clk);
`else
        sendReq(32'h5000_0000, 5'b00001, 1'b1);
        issueReq();
        respond(0, 32'h0000_0F0F, RESP_OKAY);
        respond(0, 32'h0000_F0F0, RESP_OKAY);
`endif
        checkCnt("cnt_miss_done");

        // Reset while a request waits in ISSUE with three outstanding.
        for (int i = 0; i < 3; i++) begin
            sendReq(32'h2000_0080, 5'b00010, 1'b1);
            issueReq();
        end
        sendReq(32'h2000_0040, 5'b00010, 1'b1);
        #1;
        checkOutput("pre_rst_issue_valid", 64'(m_addr_valid), 64'd2);
        checkCnt("pre_rst_cnt");
        rst = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("mid_rst_valid", 64'(m_addr_valid), 64'd0);
        checkOutput("mid_rst_cnt", 64'(dut.cnt_q), 64'd0);
        checkOutput("mid_rst_m_addr", 64'(m_addr), 64'd0);
        checkOutput("mid_rst_addr_ready", 64'(s_addr_ready), 64'd0);
        checkOutput("mid_rst_state", 64'(dut.state_q), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        req_q.delete();
        model_cnt = 0;
        #1;
        checkOutput("post_rst_addr_ready", 64'(s_addr_ready), 64'd1);
        @(negedge clk);
        applyStimulus(vecs[5]);

        checkOutput("req_queue_left", 64'(req_q.size()), 64'd0);
        checkOutput("rsp_queue_left", 64'(rsp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
